// File: rtl/kbd_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// kbd_pkg: PS/2 prefix bytes, shift scancodes and prefix-FSM states
// rev 1.0
// ------------------------------------------------------------------
package kbd_pkg;

  localparam logic [7:0] BYTE_E0  = 8'hE0;
  localparam logic [7:0] BYTE_F0  = 8'hF0;
  localparam logic [7:0] CODE_LSH = 8'h12;
  localparam logic [7:0] CODE_RSH = 8'h59;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } pfx_state_e;

  function automatic logic is_shift(input logic [7:0] code);
    return (code == CODE_LSH) || (code == CODE_RSH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_seq_prefix.sv
`default_nettype none
// ------------------------------------------------------------------
// kbd_seq_prefix: E0/F0 prefix tracker emitting make/break events
// rev 1.0
// ------------------------------------------------------------------
module kbd_seq_prefix
  import kbd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       stb_i,
  input  logic [7:0] byte_i,
  output logic       make_o,
  output logic       brk_o,
  output logic       e0_o
);

  pfx_state_e state_q, state_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign e0_o = (state_q == ST_E0) || (state_q == ST_E0F0);

  always_comb begin
    state_d = state_q;
    make_o  = 1'b0;
    brk_o   = 1'b0;
    if (stb_i) begin
      unique case (state_q)
        ST_IDLE, ST_E0: begin
          if (byte_i == BYTE_E0) begin
            state_d = ST_E0;
          end else if (byte_i == BYTE_F0) begin
            state_d = (state_q == ST_E0) ? ST_E0F0 : ST_F0;
          end else begin
            state_d = ST_IDLE;
            make_o  = 1'b1;
          end
        end
        default: begin
          // A second prefix after F0 is a protocol error: resynchronise.
          state_d = ST_IDLE;
          brk_o   = (byte_i != BYTE_E0) && (byte_i != BYTE_F0);
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/kbd_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// kbd_seq: PS/2 set-2 sequencer with shift tracking, key latch and overflow
// rev 1.0
// ------------------------------------------------------------------
module kbd_seq
  import kbd_pkg::*;
#(
  parameter bit FILTER_RPT = 1'b0
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       scan_stb,
  input  logic [7:0] scan_code,
  output logic       tr_shift,
  output logic       tr_e0,
  output logic [7:0] tr_code,
  input  logic [6:0] tr_out,
  input  logic       tr_ar2,
  output logic [6:0] key_data,
  output logic       key_ar2,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       key_ovf
);

  logic ev_make, ev_brk, ev_e0;

  kbd_seq_prefix u_prefix (
    .clk_i  (clk_sys),
    .rst_ni (reset_n),
    .stb_i  (scan_stb),
    .byte_i (scan_code),
    .make_o (ev_make),
    .brk_o  (ev_brk),
    .e0_o   (ev_e0)
  );

  logic       lsh_q, rsh_q;
  logic       lk1_q, lk2_q;
  logic [7:0] tr_code_q;
  logic       tr_e0_q;
  logic [6:0] key_data_q;
  logic       key_ar2_q, key_valid_q, key_ovf_q, key_down_q;
  logic [8:0] last_q;

  logic [8:0] ev_key;
  logic       repeat_hit, issue, accept;

  assign ev_key     = {ev_e0, scan_code};
  assign repeat_hit = FILTER_RPT && key_down_q && (ev_key == last_q);
  // Shift keys only steer the translator; they never produce a code.
  assign issue      = ev_make && !is_shift(scan_code) && !lk1_q && !lk2_q && !repeat_hit;
  assign accept     = lk2_q && (tr_out != 7'd0);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lsh_q       <= 1'b0;
      rsh_q       <= 1'b0;
      lk1_q       <= 1'b0;
      lk2_q       <= 1'b0;
      tr_code_q   <= 8'd0;
      tr_e0_q     <= 1'b0;
      key_data_q  <= 7'd0;
      key_ar2_q   <= 1'b0;
      key_valid_q <= 1'b0;
      key_ovf_q   <= 1'b0;
      key_down_q  <= 1'b0;
      last_q      <= 9'd0;
    end else begin
      lk1_q <= issue;
      lk2_q <= lk1_q;
      if (issue) begin
        tr_code_q <= scan_code;
        tr_e0_q   <= ev_e0;
      end

      // E0-prefixed 12/59 are fake shifts and leave the levels alone.
      if ((ev_make || ev_brk) && !ev_e0) begin
        if (scan_code == CODE_LSH) lsh_q <= ev_make;
        if (scan_code == CODE_RSH) rsh_q <= ev_make;
      end

      if (accept) begin
        last_q     <= {tr_e0_q, tr_code_q};
        key_down_q <= 1'b1;
      end else if (ev_brk && (ev_key == last_q)) begin
        key_down_q <= 1'b0;
      end

      if (accept && (!key_valid_q || key_ack)) begin
        key_data_q  <= tr_out;
        key_ar2_q   <= tr_ar2;
        key_valid_q <= 1'b1;
      end else if (key_ack) begin
        key_valid_q <= 1'b0;
      end

      if (key_ack) begin
        key_ovf_q <= 1'b0;
      end else if (accept && key_valid_q) begin
        key_ovf_q <= 1'b1;
      end
    end
  end

  assign tr_shift  = lsh_q | rsh_q;
  assign tr_e0     = tr_e0_q;
  assign tr_code   = tr_code_q;
  assign key_data  = key_data_q;
  assign key_ar2   = key_ar2_q;
  assign key_valid = key_valid_q;
  assign key_ovf   = key_ovf_q;
  assign key_down  = key_down_q;

endmodule
`default_nettype wire

// File: tb/tb_kbd_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_kbd_seq: two sequencers (repeat filter off/on) against a behavioural model
// rev 1.0
// ------------------------------------------------------------------
module tb_kbd_seq;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b1;
  logic       scan_stb = 1'b0;
  logic [7:0] scan_code = 8'd0;
  logic       key_ack = 1'b0;

  always #5 clk_sys = ~clk_sys;

  logic [1:0] tr_shift, tr_e0, tr_ar2, key_ar2, key_valid, key_down, key_ovf;
  logic [7:0] tr_code [2];
  logic [6:0] tr_out [2];
  logic [6:0] key_data [2];

  // Translator stand-in: only the codes the directed vectors use are mapped.
  function automatic logic [7:0] xlate(input logic sh, input logic e0, input logic [7:0] c);
    logic [7:0] r;
    r = 8'h00;
    if (!e0) begin
      case (c)
        8'h1C:   r = sh ? 8'h41 : 8'h61;
        8'h32:   r = sh ? 8'h42 : 8'h62;
        8'h05:   r = {1'b1, 7'o001};
        default: r = 8'h00;
      endcase
    end else if (c == 8'h75) begin
      r = {1'b0, 7'o032};
    end
    return r;
  endfunction

  assign {tr_ar2[0], tr_out[0]} = xlate(tr_shift[0], tr_e0[0], tr_code[0]);
  assign {tr_ar2[1], tr_out[1]} = xlate(tr_shift[1], tr_e0[1], tr_code[1]);

  kbd_seq #(.FILTER_RPT(1'b0)) u_dut0 (
    .clk_sys(clk_sys), .reset_n(reset_n), .scan_stb(scan_stb), .scan_code(scan_code),
    .tr_shift(tr_shift[0]), .tr_e0(tr_e0[0]), .tr_code(tr_code[0]),
    .tr_out(tr_out[0]), .tr_ar2(tr_ar2[0]),
    .key_data(key_data[0]), .key_ar2(key_ar2[0]), .key_valid(key_valid[0]),
    .key_ack(key_ack), .key_down(key_down[0]), .key_ovf(key_ovf[0])
  );

  kbd_seq #(.FILTER_RPT(1'b1)) u_dut1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .scan_stb(scan_stb), .scan_code(scan_code),
    .tr_shift(tr_shift[1]), .tr_e0(tr_e0[1]), .tr_code(tr_code[1]),
    .tr_out(tr_out[1]), .tr_ar2(tr_ar2[1]),
    .key_data(key_data[1]), .key_ar2(key_ar2[1]), .key_valid(key_valid[1]),
    .key_ack(key_ack), .key_down(key_down[1]), .key_ovf(key_ovf[1])
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (per instance) ----------------
  bit   [1:0] m_pe0 = '0, m_pf0 = '0, m_lsh = '0, m_rsh = '0;
  bit   [1:0] m_pend = '0, m_down = '0, m_valid = '0, m_ovf = '0, m_ar2 = '0, m_tre0 = '0;
  bit   [1:0] m_ie0 = '0;
  int         m_cnt [2] = '{0, 0};
  logic [7:0] m_icode [2] = '{8'd0, 8'd0};
  logic [7:0] m_trc [2] = '{8'd0, 8'd0};
  logic [6:0] m_data [2] = '{7'd0, 7'd0};
  logic [8:0] m_last [2] = '{9'd0, 9'd0};

  task automatic model_reset();
    m_pe0 = '0; m_pf0 = '0; m_lsh = '0; m_rsh = '0; m_pend = '0; m_down = '0;
    m_valid = '0; m_ovf = '0; m_ar2 = '0; m_tre0 = '0; m_ie0 = '0;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_icode[i] = 8'd0; m_trc[i] = 8'd0; m_data[i] = 7'd0; m_last[i] = 9'd0;
    end
  endtask

  task automatic model_step(input int i);
    logic [7:0] t;
    logic inflight, acc, was_full, e0, brk;
    inflight = m_pend[i];
    acc = 1'b0;
    t = 8'd0;
    // A lookup issued on edge n is judged on edge n+2.
    if (m_pend[i]) begin
      if (m_cnt[i] > 0) m_cnt[i]--;
      else begin
        m_pend[i] = 1'b0;
        t = xlate(m_lsh[i] | m_rsh[i], m_ie0[i], m_icode[i]);
        acc = (t[6:0] != 7'd0);
      end
    end
    was_full = m_valid[i] && !key_ack;
    if (key_ack) begin
      m_valid[i] = 1'b0;
      m_ovf[i] = 1'b0;
    end
    if (acc) begin
      m_last[i] = {m_ie0[i], m_icode[i]};
      m_down[i] = 1'b1;
      if (was_full) m_ovf[i] = 1'b1;
      else begin
        m_data[i] = t[6:0];
        m_ar2[i] = t[7];
        m_valid[i] = 1'b1;
      end
    end
    if (scan_stb) begin
      if (scan_code == 8'hE0 || scan_code == 8'hF0) begin
        if (m_pf0[i]) begin
          m_pe0[i] = 1'b0;
          m_pf0[i] = 1'b0;
        end else if (scan_code == 8'hE0) m_pe0[i] = 1'b1;
        else m_pf0[i] = 1'b1;
      end else begin
        e0 = m_pe0[i];
        brk = m_pf0[i];
        m_pe0[i] = 1'b0;
        m_pf0[i] = 1'b0;
        if (!e0 && scan_code == 8'h12) m_lsh[i] = !brk;
        if (!e0 && scan_code == 8'h59) m_rsh[i] = !brk;
        if (brk) begin
          if ({e0, scan_code} == m_last[i]) m_down[i] = 1'b0;
        end else if (scan_code != 8'h12 && scan_code != 8'h59 && !inflight &&
                     !(i == 1 && m_down[i] && {e0, scan_code} == m_last[i])) begin
          m_pend[i] = 1'b1;
          m_cnt[i] = 1;
          m_ie0[i] = e0;
          m_icode[i] = scan_code;
          m_trc[i] = scan_code;
          m_tre0[i] = e0;
        end
      end
    end
  endtask

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) model_reset();
    else for (int i = 0; i < 2; i++) model_step(i);
  end

  always @(negedge clk_sys) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("dut%0d.key_data", i), {2'b0, key_data[i]}, {2'b0, m_data[i]});
        chk($sformatf("dut%0d.key_valid", i), {8'b0, key_valid[i]}, {8'b0, m_valid[i]});
        chk($sformatf("dut%0d.key_ovf", i), {8'b0, key_ovf[i]}, {8'b0, m_ovf[i]});
        chk($sformatf("dut%0d.key_ar2", i), {8'b0, key_ar2[i]}, {8'b0, m_ar2[i]});
        chk($sformatf("dut%0d.key_down", i), {8'b0, key_down[i]}, {8'b0, m_down[i]});
        chk($sformatf("dut%0d.tr_shift", i), {8'b0, tr_shift[i]}, {8'b0, m_lsh[i] | m_rsh[i]});
        chk($sformatf("dut%0d.tr_code", i), {1'b0, tr_code[i]}, {1'b0, m_trc[i]});
        chk($sformatf("dut%0d.tr_e0", i), {8'b0, tr_e0[i]}, {8'b0, m_tre0[i]});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    scan_stb = 1'b1;
    scan_code = b;
    tick();
    scan_stb = 1'b0;
    repeat (5) tick();
  endtask

  task automatic send2(input logic [7:0] a, input logic [7:0] b);
    send(a);
    send(b);
  endtask

  task automatic ack();
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1);
  end

  initial begin
    #2 reset_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    chk("reset.key_valid", {8'b0, key_valid[0]}, 9'd0);
    chk("reset.key_data", {2'b0, key_data[0]}, 9'd0);
    chk("reset.tr_code", {1'b0, tr_code[0]}, 9'd0);

    // Plain make / break
    send(8'h1C);
    chk("1C.key_data", {2'b0, key_data[0]}, 9'h061);
    chk("1C.key_valid", {8'b0, key_valid[0]}, 9'd1);
    chk("1C.key_down", {8'b0, key_down[0]}, 9'd1);
    send2(8'hF0, 8'h1C);
    chk("F0_1C.key_down", {8'b0, key_down[0]}, 9'd0);
    ack();
    chk("ack.key_valid", {8'b0, key_valid[0]}, 9'd0);

    // Left shift
    send(8'h12);
    chk("12.tr_shift", {8'b0, tr_shift[0]}, 9'd1);
    send(8'h1C);
    chk("12_1C.key_data", {2'b0, key_data[0]}, 9'h041);
    send2(8'hF0, 8'h1C);
    ack();
    send2(8'hF0, 8'h12);
    chk("F0_12.tr_shift", {8'b0, tr_shift[0]}, 9'd0);
    send(8'h1C);
    chk("unshift_1C.key_data", {2'b0, key_data[0]}, 9'h061);
    ack();
    send2(8'hF0, 8'h1C);

    // Fake shift and E0 keys
    send2(8'hE0, 8'h12);
    chk("E0_12.tr_shift", {8'b0, tr_shift[0]}, 9'd0);
    send(8'h1C);
    chk("fake_1C.key_data", {2'b0, key_data[0]}, 9'h061);
    ack();
    send2(8'hF0, 8'h1C);
    send(8'hE0);
    send2(8'hF0, 8'h12);
    send2(8'hE0, 8'h75);
    chk("E0_75.tr_e0", {8'b0, tr_e0[0]}, 9'd1);
    chk("E0_75.key_data", {2'b0, key_data[0]}, 9'h01A);
    ack();
    send(8'hE0);
    send2(8'hF0, 8'h75);

    // AR2 key, unmapped key, protocol error
    send(8'h05);
    chk("05.key_data", {2'b0, key_data[0]}, 9'h001);
    chk("05.key_ar2", {8'b0, key_ar2[0]}, 9'd1);
    ack();
    send(8'h0C);
    chk("0C.key_valid", {8'b0, key_valid[0]}, 9'd0);
    chk("0C.key_down", {8'b0, key_down[0]}, 9'd1);
    send2(8'hF0, 8'hE0);
    send(8'h1C);
    chk("err_1C.key_valid", {8'b0, key_valid[0]}, 9'd1);
    chk("err_1C.key_data", {2'b0, key_data[0]}, 9'h061);
    ack();
    send2(8'hF0, 8'h1C);

    // Overflow and ack/accept collision
    send2(8'h1C, 8'h32);
    chk("ovf.key_data", {2'b0, key_data[0]}, 9'h061);
    chk("ovf.key_ovf", {8'b0, key_ovf[0]}, 9'd1);
    ack();
    chk("ovf_ack.key_valid", {8'b0, key_valid[0]}, 9'd0);
    chk("ovf_ack.key_ovf", {8'b0, key_ovf[0]}, 9'd0);
    send2(8'h1C, 8'h32);
    scan_stb = 1'b1;
    scan_code = 8'h05;
    tick();
    scan_stb = 1'b0;
    tick();
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    repeat (3) tick();
    chk("coll.key_data", {2'b0, key_data[0]}, 9'h001);
    chk("coll.key_valid", {8'b0, key_valid[0]}, 9'd1);
    chk("coll.key_ovf", {8'b0, key_ovf[0]}, 9'd0);
    ack();
    send2(8'hF0, 8'h05);

    // Typematic repeats
    send(8'h1C);
    send2(8'h1C, 8'h1C);
    chk("rpt.dut1.key_valid", {8'b0, key_valid[1]}, 9'd1);
    chk("rpt.dut1.key_ovf", {8'b0, key_ovf[1]}, 9'd0);
    chk("rpt.dut0.key_ovf", {8'b0, key_ovf[0]}, 9'd1);
    ack();
    send2(8'hF0, 8'h1C);

    // Reset with a lookup in flight
    scan_stb = 1'b1;
    scan_code = 8'h1C;
    tick();
    scan_stb = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    chk("rst_fl.key_valid", {8'b0, key_valid[0]}, 9'd0);
    chk("rst_fl.key_data", {2'b0, key_data[0]}, 9'd0);
    chk("rst_fl.key_down", {8'b0, key_down[0]}, 9'd0);
    chk("rst_fl.tr_code", {1'b0, tr_code[0]}, 9'd0);

    // Strobe in the very first cycle after reset release
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    send(8'h1C);
    chk("post_rst.key_data", {2'b0, key_data[0]}, 9'h061);
    chk("post_rst.key_valid", {8'b0, key_valid[0]}, 9'd1);

    repeat (2) tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
